risc8_fetch_unit: RTL and testbench

Instruction fetch stage for the 8-bit pipelined RISC core. It sits directly upstream of decode. It generates the PC, reads instruction memory (synchronous, 1-cycle read latency), and buffers fetched {pc, instr} pairs in a small prefetch queue. Decode consumes entries with a valid/ready handshake. The execute stage redirects the fetch PC on a taken BEQ, BNE or JUMP.

---
 rtl/risc8_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_risc8_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/risc8_fetch_unit.sv
// Fetch stage: PC generation, 1-cycle instruction memory read, and a prefetch queue feeding decode.
// Define FETCH_PERF_EN to add saturating perf counters (pops, stall cycles, redirects).
module risc8_fetch_unit #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       INSTR_W  = 8,
  parameter int unsigned       QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_rd_en_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               redirect_valid_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  input  logic               out_ready_i,
  output logic               out_valid_o,
  output logic [INSTR_W-1:0] out_instr_o,
  output logic [ADDR_W-1:0]  out_pc_o,
`ifdef FETCH_PERF_EN
  output logic [15:0]        perf_fetched_o,
  output logic [15:0]        perf_stall_cycles_o,
  output logic [15:0]        perf_flushes_o,
`endif
  output logic [ADDR_W-1:0]  fetch_pc_o
);

  localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned UseW = CntW + 1;

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0]    head_q, head_d;
  logic [PtrW-1:0]    tail_q, tail_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic [ADDR_W-1:0]  pc_mem_q    [QDEPTH];
  logic [INSTR_W-1:0] instr_mem_q [QDEPTH];

  logic [UseW-1:0] used;
  logic            issue;
  logic            push;
  logic            pop;

  // Credit check counts the outstanding read so the queue can never overflow.
  assign used  = {1'b0, count_q} + UseW'(inflight_q);
  assign issue = reset & ~redirect_valid_i & (used < UseW'(QDEPTH));
  assign push  = inflight_q & ~redirect_valid_i;
  assign pop   = out_valid_o & out_ready_i & ~redirect_valid_i;

  assign imem_rd_en_o = issue;
  assign imem_addr_o  = fetch_pc_q;
  assign fetch_pc_o   = fetch_pc_q;
  assign out_valid_o  = (count_q != '0);
  assign out_instr_o  = instr_mem_q[head_q];
  assign out_pc_o     = pc_mem_q[head_q];

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid_i) begin
      fetch_pc_d = redirect_pc_i;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
      end
      if (push) tail_d = tail_q + PtrW'(1);
      if (pop)  head_d = head_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // Storage cleared on reset so the empty-queue head reads zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(QDEPTH); i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[tail_q]    <= inflight_pc_q;
      instr_mem_q[tail_q] <= imem_rdata_i;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched_q, perf_stall_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
      perf_flush_q   <= '0;
    end else begin
      if (pop && (perf_fetched_q != 16'hffff)) perf_fetched_q <= perf_fetched_q + 16'd1;
      if (out_valid_o && !out_ready_i && (perf_stall_q != 16'hffff)) begin
        perf_stall_q <= perf_stall_q + 16'd1;
      end
      if (redirect_valid_i && (perf_flush_q != 16'hffff)) perf_flush_q <= perf_flush_q + 16'd1;
    end
  end

  assign perf_fetched_o      = perf_fetched_q;
  assign perf_stall_cycles_o = perf_stall_q;
  assign perf_flushes_o      = perf_flush_q;
`endif

endmodule

// File: tb/tb_risc8_fetch_unit.sv
// Bench for risc8_fetch_unit: queue-level reference model checked every cycle, plus directed
// literal checks for startup, stall, redirect, wrap-around and mid-stream reset.
module tb_risc8_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       imem_rd_en;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata = 8'h00;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_instr;
  logic [7:0] out_pc;
  logic [7:0] fetch_pc;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: queue of {pc, instr}, one pending read, next PC.
  logic [15:0] mq[$];
  bit          mpend = 1'b0;
  logic [7:0]  mpend_pc = 8'h00;
  logic [7:0]  mpc = 8'h00;

  always #5 clk = ~clk;

  risc8_fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .imem_rd_en_o     (imem_rd_en),
    .imem_addr_o      (imem_addr),
    .imem_rdata_i     (imem_rdata),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .out_ready_i      (out_ready),
    .out_valid_o      (out_valid),
    .out_instr_o      (out_instr),
    .out_pc_o         (out_pc),
    .fetch_pc_o       (fetch_pc)
  );

  // Instruction memory: contents are pc + 16, one-cycle read latency.
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= imem_addr + 8'd16;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic rdy, input logic rv, input logic [7:0] rpc, input logic rstn);
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    reset          = rstn;
  endtask

  // Compare DUT outputs against the model mid-cycle.
  task automatic sample();
    logic        exp_en;
    logic [15:0] h;
    @(negedge clk);
    exp_en = reset && !redirect_valid && ((mq.size() + int'(mpend)) < 4);
    check("imem_rd_en", 8'(imem_rd_en), 8'(exp_en));
    check("imem_addr", imem_addr, mpc);
    check("fetch_pc", fetch_pc, mpc);
    check("out_valid", 8'(out_valid), 8'(mq.size() != 0));
    if (mq.size() != 0) begin
      h = mq[0];
      check("out_pc", out_pc, h[15:8]);
      check("out_instr", out_instr, h[7:0]);
    end
  endtask

  // Apply the clock edge to the model, then wait for the DUT edge.
  task automatic advance();
    bit do_pop, do_issue;
    if (!reset) begin
      mq.delete();
      mpend = 1'b0;
      mpc   = 8'h00;
    end else if (redirect_valid) begin
      mq.delete();
      mpend = 1'b0;
      mpc   = redirect_pc;
    end else begin
      do_pop   = (mq.size() != 0) && out_ready;
      do_issue = (mq.size() + int'(mpend)) < 4;
      if (do_pop) void'(mq.pop_front());
      if (mpend) mq.push_back({mpend_pc, mpend_pc + 8'd16});
      mpend = do_issue;
      if (do_issue) begin
        mpend_pc = mpc;
        mpc      = mpc + 8'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic rdy, input logic rv, input logic [7:0] rpc, input logic rstn);
    set_in(rdy, rv, rpc, rstn);
    sample();
  endtask

  task automatic step(input logic rdy, input logic rv, input logic [7:0] rpc, input logic rstn);
    cyc(rdy, rv, rpc, rstn);
    advance();
  endtask

  initial begin
    set_in(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    cyc(1, 0, 0, 0);
    check("rst_rd_en", 8'(imem_rd_en), 8'd0);
    check("rst_out_valid", 8'(out_valid), 8'd0);
    check("rst_out_instr", out_instr, 8'd0);
    check("rst_out_pc", out_pc, 8'd0);
    check("rst_fetch_pc", fetch_pc, 8'd0);
    advance();

    // Startup: issue immediately, first output two cycles later, then one per cycle.
    cyc(1, 0, 0, 1);
    check("start_rd_en", 8'(imem_rd_en), 8'd1);
    check("start_addr", imem_addr, 8'd0);
    advance();
    cyc(1, 0, 0, 1);
    check("start_c1_valid", 8'(out_valid), 8'd0);
    advance();
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 1);
      check("start_valid", 8'(out_valid), 8'd1);
      check("start_pc", out_pc, 8'(i));
      check("start_instr", out_instr, 8'(i + 16));
      advance();
    end

    // Stall from a fresh reset: queue fills, head frozen at PC 0, then drains in order.
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    check("stall_rd_en", 8'(imem_rd_en), 8'd0);
    check("stall_valid", 8'(out_valid), 8'd1);
    check("stall_pc", out_pc, 8'd0);
    advance();
    for (int i = 1; i < 6; i++) begin
      cyc(1, 0, 0, 1);
      check("drain_valid", 8'(out_valid), 8'd1);
      check("drain_pc", out_pc, 8'(i));
      advance();
    end

    // Redirect into a full queue: two bubbles, then the target.
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
    step(0, 1, 8'd12, 1);
    cyc(1, 0, 0, 1);
    check("redir_b1_valid", 8'(out_valid), 8'd0);
    advance();
    cyc(1, 0, 0, 1);
    check("redir_b2_valid", 8'(out_valid), 8'd0);
    advance();
    cyc(1, 0, 0, 1);
    check("redir_valid", 8'(out_valid), 8'd1);
    check("redir_pc", out_pc, 8'd12);
    check("redir_instr", out_instr, 8'd28);
    advance();

    // Back-to-back redirects: last one wins.
    step(1, 1, 8'd20, 1);
    step(1, 1, 8'd40, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    check("b2b_pc", out_pc, 8'd40);
    advance();

    // PC wrap-around.
    step(1, 1, 8'd254, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 1);
      check("wrap_pc", out_pc, 8'(254 + i));
      advance();
    end

    // Reset with a full queue.
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    check("mrst_valid", 8'(out_valid), 8'd0);
    check("mrst_rd_en", 8'(imem_rd_en), 8'd1);
    check("mrst_addr", imem_addr, 8'd0);
    advance();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 10) < 7, ($urandom % 10) == 0, 8'($urandom), ($urandom % 100) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
